ping_pong_lane_buffer: RTL and testbench

- Parametrised double-buffered (ping-pong) sample buffer for the note-lane / VGA path.
- A producer fills the back bank through a valid/ready handshake while a consumer streams the front bank one entry per read strobe.
- Banks swap automatically once the back bank is full and the front bank is drained.
- An external read-strobe input takes the place of a dedicated divided clock, and the block adds underrun reporting, flush and a frame counter.

---
 rtl/ping_pong_lane_buffer.sv | 158 +++++++++++++++
 tb/tb_ping_pong_lane_buffer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/ping_pong_lane_buffer.sv
// Double-buffered lane sample buffer: producer fills the back bank, consumer drains the front bank.
// Optional replay of the front bank on underrun is enabled by defining PPLB_REPEAT_EN.
module ping_pong_lane_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int FCNT_W = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_tick,
  output logic [DATA_W-1:0] y,
  output logic              y_valid,
  output logic              underrun,
  output logic              bank_sel,
  output logic [FCNT_W-1:0] frame_cnt
);

  // Both banks share one array; the top address bit selects the bank.
  logic [DATA_W-1:0] mem [2*DEPTH];

  logic [DATA_W-1:0] y_q, y_d;
  logic              y_valid_q, y_valid_d;
  logic              underrun_q, underrun_d;
  logic              bank_sel_q, bank_sel_d;
  logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic              back_full_q, back_full_d;
  logic              front_empty_q, front_empty_d;
`ifdef PPLB_REPEAT_EN
  logic              loaded_q, loaded_d;
`endif

  logic              wr_fire;
  logic              rd_fire;
  logic              replay;
  logic              swap;
  logic [ADDR_W:0]   wr_addr;

  assign wr_ready = !back_full_q && !flush;
  assign wr_fire  = wr_valid && wr_ready;
  assign wr_addr  = {~bank_sel_q, wr_ptr_q};
  assign swap     = back_full_q && front_empty_q;
  assign rd_fire  = rd_tick && !front_empty_q;
`ifdef PPLB_REPEAT_EN
  assign replay   = rd_tick && front_empty_q && loaded_q && !back_full_q;
`else
  assign replay   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    y_d           = y_q;
    y_valid_d     = 1'b0;
    underrun_d    = 1'b0;
    bank_sel_d    = bank_sel_q;
    frame_cnt_d   = frame_cnt_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    back_full_d   = back_full_q;
    front_empty_d = front_empty_q;
`ifdef PPLB_REPEAT_EN
    loaded_d      = loaded_q;
`endif
    if (flush) begin
      y_d           = '0;
      bank_sel_d    = 1'b0;
      frame_cnt_d   = '0;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      back_full_d   = 1'b0;
      front_empty_d = 1'b1;
`ifdef PPLB_REPEAT_EN
      loaded_d      = 1'b0;
`endif
    end else begin
      if (wr_fire) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (wr_ptr_q == ADDR_W'(DEPTH - 1)) begin
          back_full_d = 1'b1;
        end
      end
      // A swap needs front_empty, so it never coincides with a served read.
      if (swap) begin
        bank_sel_d    = ~bank_sel_q;
        back_full_d   = 1'b0;
        front_empty_d = 1'b0;
        rd_ptr_d      = '0;
        frame_cnt_d   = frame_cnt_q + 1'b1;
`ifdef PPLB_REPEAT_EN
        loaded_d      = 1'b1;
`endif
      end
      if (rd_fire) begin
        y_d       = mem[{bank_sel_q, rd_ptr_q}];
        y_valid_d = 1'b1;
        rd_ptr_d  = rd_ptr_q + 1'b1;
        if (rd_ptr_q == ADDR_W'(DEPTH - 1)) begin
          front_empty_d = 1'b1;
        end
      end else if (replay) begin
        y_d           = mem[{bank_sel_q, {ADDR_W{1'b0}}}];
        y_valid_d     = 1'b1;
        rd_ptr_d      = ADDR_W'(1);
        front_empty_d = 1'b0;
      end else if (rd_tick) begin
        underrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      y_q           <= '0;
      y_valid_q     <= 1'b0;
      underrun_q    <= 1'b0;
      bank_sel_q    <= 1'b0;
      frame_cnt_q   <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      back_full_q   <= 1'b0;
      front_empty_q <= 1'b1;
`ifdef PPLB_REPEAT_EN
      loaded_q      <= 1'b0;
`endif
    end else begin
      y_q           <= y_d;
      y_valid_q     <= y_valid_d;
      underrun_q    <= underrun_d;
      bank_sel_q    <= bank_sel_d;
      frame_cnt_q   <= frame_cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      back_full_q   <= back_full_d;
      front_empty_q <= front_empty_d;
`ifdef PPLB_REPEAT_EN
      loaded_q      <= loaded_d;
`endif
    end
  end

  assign y         = y_q;
  assign y_valid   = y_valid_q;
  assign underrun  = underrun_q;
  assign bank_sel  = bank_sel_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_ping_pong_lane_buffer.sv
// Randomized and directed bench for ping_pong_lane_buffer against a queue-based bank model.
// Compile with PPLB_REPEAT_EN defined to exercise the replay build.
module tb_ping_pong_lane_buffer;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 32;
  localparam int FCNT_W = 8;

  logic              clk = 1'b0;
  logic              resetn;
  logic              flush;
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              rd_tick;
  logic [DATA_W-1:0] y;
  logic              y_valid;
  logic              underrun;
  logic              bank_sel;
  logic [FCNT_W-1:0] frame_cnt;

  int total = 0;
  int bad   = 0;

  // Model: back bank holds what was written, front bank holds what is left to read.
  int back_q[$];
  int front_q[$];
  int last_bank[DEPTH];
  bit m_loaded;
  bit m_bank;
  int m_y;
  bit m_yv;
  bit m_un;
  int m_fc;

  ping_pong_lane_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .FCNT_W(FCNT_W)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_tick(rd_tick), .y(y), .y_valid(y_valid), .underrun(underrun),
    .bank_sel(bank_sel), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    back_q.delete();
    front_q.delete();
    m_loaded = 1'b0;
    m_bank   = 1'b0;
    m_y      = 0;
    m_yv     = 1'b0;
    m_un     = 1'b0;
    m_fc     = 0;
  endtask

  task automatic model_step(input bit v, input int d, input bit t, input bit f);
    bit do_swap;
    bit can_replay;
    if (f) begin
      model_clear();
      return;
    end
    do_swap = (back_q.size() == DEPTH) && (front_q.size() == 0);
    m_yv = 1'b0;
    m_un = 1'b0;
`ifdef PPLB_REPEAT_EN
    can_replay = m_loaded && (back_q.size() != DEPTH);
`else
    can_replay = 1'b0;
`endif
    if (t) begin
      if (front_q.size() > 0) begin
        m_y  = front_q.pop_front();
        m_yv = 1'b1;
      end else if (can_replay) begin
        m_y  = last_bank[0];
        m_yv = 1'b1;
        for (int i = 1; i < DEPTH; i++) front_q.push_back(last_bank[i]);
      end else begin
        m_un = 1'b1;
      end
    end
    if (do_swap) begin
      for (int i = 0; i < DEPTH; i++) last_bank[i] = back_q[i];
      front_q  = back_q;
      back_q.delete();
      m_bank   = ~m_bank;
      m_fc     = m_fc + 1;
      m_loaded = 1'b1;
    end else if (v && back_q.size() < DEPTH) begin
      back_q.push_back(d & 8'hFF);
    end
  endtask

  // One clock cycle: drive at the falling edge, check outputs at the next falling edge.
  task automatic step(input bit v, input int d, input bit t, input bit f);
    wr_valid = v;
    wr_data  = d[DATA_W-1:0];
    rd_tick  = t;
    flush    = f;
    #1;
    check_val("wr_ready", int'(wr_ready), int'(back_q.size() < DEPTH && !f));
    model_step(v, d, t, f);
    @(posedge clk);
    @(negedge clk);
    check_val("y", int'(y), m_y);
    check_val("y_valid", int'(y_valid), int'(m_yv));
    check_val("underrun", int'(underrun), int'(m_un));
    check_val("bank_sel", int'(bank_sel), int'(m_bank));
    check_val("frame_cnt", int'(frame_cnt), m_fc % (1 << FCNT_W));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_y"}, int'(y), 0);
    check_val({tag, "_y_valid"}, int'(y_valid), 0);
    check_val({tag, "_underrun"}, int'(underrun), 0);
    check_val({tag, "_bank_sel"}, int'(bank_sel), 0);
    check_val({tag, "_frame_cnt"}, int'(frame_cnt), 0);
    check_val({tag, "_wr_ready"}, int'(wr_ready), 1);
  endtask

  initial begin
    resetn = 1'b0; flush = 1'b0; wr_valid = 1'b0; wr_data = '0; rd_tick = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    resetn = 1'b1;

    // Fill bank 1 with 0..31, then the idle swap cycle.
    for (int i = 0; i < DEPTH; i++) step(1'b1, i, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0);
    // Drain bank 1 while filling the other bank with 100..131.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 100 + i, 1'b1, 1'b0);
    // Tick lands in the swap cycle, then the new front streams out.
    step(1'b0, 0, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 0, 1'b1, 1'b0);
    // Ticks against an empty front bank.
    for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b1, 1'b0);
    // Partial activity, then flush and a fresh fill.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 200 + i, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 50 + i, (i < 5), 1'b0);
    step(1'b0, 0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH + 1; i++) step(1'b1, 7 * i, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 0, 1'b1, 1'b0);

    // Random traffic with occasional flushes.
    for (int n = 0; n < 3000; n++)
      step($urandom_range(0, 9) < 6, int'($urandom_range(0, 255)),
           $urandom_range(0, 9) < 5, $urandom_range(0, 199) == 0);

    // Asynchronous reset mid-stream must clear outputs before any clock edge.
    #2;
    resetn = 1'b0; wr_valid = 1'b0; rd_tick = 1'b0; flush = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    model_clear();
    @(negedge clk);
    resetn = 1'b1;
    for (int n = 0; n < 500; n++)
      step($urandom_range(0, 9) < 7, int'($urandom_range(0, 255)),
           $urandom_range(0, 9) < 4, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
